// File: rtl/adaptive_filter_mc.sv
// ---------------------------------------------------------------------------
// adaptive_filter_mc
//
// Multi-channel (TDM) first-order filter with a one-entry registered output
// stage. Each channel keeps one WORDLENGTH-bit state word. The active mode
// (ctrl_q) selects the operation:
//   0 differentiate   y = x - st          st <= x
//   1 integrate       y = st + x          st <= y
//   2 bypass          y = x               st <= x
//   3 leaky integrate y = st - (st>>>LEAK_SHIFT) + x, st <= y
// Results are saturated to the signed WORDLENGTH range. m_tsat flags a
// clipped result. A change on ctrl stalls input for one cycle and clears
// every channel's state.
//
// Ports
//   clk       in   rising-edge clock
//   srst_n    in   asynchronous active-low reset
//   ctrl      in   requested mode (2 bits)
//   s_tdata   in   input sample (signed, WORDLENGTH)
//   s_tid     in   input channel index
//   s_tvalid  in   input beat valid
//   s_tready  out  input beat accepted when s_tvalid && s_tready
//   m_tdata   out  filtered sample (signed, WORDLENGTH)
//   m_tid     out  channel of m_tdata
//   m_tsat    out  m_tdata was clipped
//   m_tvalid  out  output beat valid
//   m_tready  in   downstream accepts when m_tvalid && m_tready
//
// FRACTIONAL_LENGTH is a Q-format annotation only; no rescaling is applied.
// ---------------------------------------------------------------------------
module adaptive_filter_mc #(
    parameter int WORDLENGTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6,
    parameter int CHANNELS          = 4,
    parameter int LEAK_SHIFT        = 4,
    parameter bit SIM_EN            = 1'b0,
    localparam int TW               = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [1:0]            ctrl,
    input  logic [WORDLENGTH-1:0] s_tdata,
    input  logic [TW-1:0]         s_tid,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [WORDLENGTH-1:0] m_tdata,
    output logic [TW-1:0]         m_tid,
    output logic                  m_tsat,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    typedef enum logic [1:0] {
        MODE_DIFF   = 2'd0,
        MODE_INT    = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_LEAKY  = 2'd3
    } mode_e;

    localparam int XW = WORDLENGTH + 2;

    // Saturation bounds in the widened domain; ~MAX is exactly -2^(W-1).
    localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (WORDLENGTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

    // Elaboration-time parameter sanity checks.
    if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH > WORDLENGTH) begin : g_bad_frac
        $error("adaptive_filter_mc: FRACTIONAL_LENGTH out of range");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > WORDLENGTH - 1) begin : g_bad_leak
        $error("adaptive_filter_mc: LEAK_SHIFT out of range");
    end
    if (CHANNELS < 1) begin : g_bad_ch
        $error("adaptive_filter_mc: CHANNELS must be >= 1");
    end

    mode_e                         ctrl_q;
    logic signed [WORDLENGTH-1:0]  st [CHANNELS];

    logic                          mode_chg;
    logic                          accept;
    logic                          valid_id;
    logic [TW-1:0]                 rd_idx;

    logic signed [WORDLENGTH-1:0]  x_in;
    logic signed [WORDLENGTH-1:0]  st_cur;
    logic signed [XW-1:0]          x_ext;
    logic signed [XW-1:0]          st_ext;
    logic signed [XW-1:0]          leak_ext;
    logic signed [XW-1:0]          y_full;
    logic signed [XW-1:0]          y_sat;
    logic                          sat_hit;
    logic signed [WORDLENGTH-1:0]  st_next;

    // When the index space is exactly filled every s_tid is a real channel.
    if (CHANNELS == (1 << TW)) begin : g_id_full
        assign valid_id = 1'b1;
    end else begin : g_id_partial
        assign valid_id = ({1'b0, s_tid} < (TW + 1)'(CHANNELS));
    end

    assign mode_chg = (ctrl != ctrl_q);
    assign s_tready = srst_n && (!m_tvalid || m_tready) && !mode_chg;
    assign accept   = s_tvalid && s_tready;
    assign rd_idx   = valid_id ? s_tid : '0;
    assign x_in     = s_tdata;

    // Datapath: widen, apply the mode's equation, then clip. The state is
    // read straight from the register array, so a back-to-back beat on the
    // same channel always sees the value written on the previous edge.
    always_comb begin
        st_cur   = st[rd_idx];
        x_ext    = {{2{x_in[WORDLENGTH-1]}}, x_in};
        st_ext   = {{2{st_cur[WORDLENGTH-1]}}, st_cur};
        leak_ext = st_ext >>> LEAK_SHIFT;
        y_full   = '0;
        unique case (ctrl_q)
            MODE_DIFF:   y_full = x_ext - st_ext;
            MODE_INT:    y_full = st_ext + x_ext;
            MODE_BYPASS: y_full = x_ext;
            default:     y_full = st_ext - leak_ext + x_ext;
        endcase

        sat_hit = 1'b0;
        y_sat   = y_full;
        if (y_full > SAT_MAX) begin
            y_sat   = SAT_MAX;
            sat_hit = 1'b1;
        end else if (y_full < SAT_MIN) begin
            y_sat   = SAT_MIN;
            sat_hit = 1'b1;
        end

        // Differentiator and bypass remember the raw input, integrators
        // remember their (clipped) output.
        if (ctrl_q == MODE_DIFF || ctrl_q == MODE_BYPASS) begin
            st_next = x_in;
        end else begin
            st_next = y_sat[WORDLENGTH-1:0];
        end
    end

    // State, mode register and output stage. A mode change never coincides
    // with an accept (s_tready is low), so the output stage simply drains.
    // Beats for out-of-range channels are swallowed without output.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            ctrl_q   <= MODE_DIFF;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= '0;
            m_tsat   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i] <= '0;
            end
        end else begin
            if (mode_chg) begin
                ctrl_q <= mode_e'(ctrl);
                for (int i = 0; i < CHANNELS; i++) begin
                    st[i] <= '0;
                end
            end else if (accept && valid_id) begin
                st[rd_idx] <= st_next;
            end

            if (accept && valid_id) begin
                m_tvalid <= 1'b1;
                m_tdata  <= y_sat[WORDLENGTH-1:0];
                m_tid    <= s_tid;
                m_tsat   <= sat_hit;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

    if (SIM_EN) begin : g_sim_checks
        always_ff @(posedge clk) begin
            if (srst_n && accept && !valid_id) begin
                $error("adaptive_filter_mc: s_tid %0d >= CHANNELS %0d", s_tid, CHANNELS);
            end
        end
    end

endmodule
